dac_setup_sequencer: RTL
========================

Name: dac_setup_sequencer

Overview:
- Consumer of the one-cycle post-reset setup pulse in the laser projector.
- On `setup_start`, streams a fixed list of configuration words to the galvo DAC over a 3-wire serial link (`sclk`/`cs_n`/`mosi`), one word per chip-select frame.
- Reports progress on `setup_busy`, then raises `setup_done` so the downstream scan/laser logic may run.

Parameters:
- CLK_DIV, 4: `clk` cycles per `sclk` half-period; ≥1.
- WORD_BITS, 24: bits per DAC word, MSB first.
- NUM_WORDS, 4: number of configuration words sent per sequence; ≥1.
- GAP_CYCLES, 8: `clk` cycles `cs_n` stays high between words; ≥1.

Ports:
- clk, input, 1: system clock, single clock domain.
- reset, input, 1: synchronous, active-high reset.
- setup_start, input, 1: one-cycle start pulse.
- dac_sclk, output, 1: serial clock; idles low.
- dac_cs_n, output, 1: active-low frame select; idles high.
- dac_mosi, output, 1: serial data.
- setup_busy, output, 1: high while a sequence is running.
- setup_done, output, 1: high after the last word completes; held until reset or restart.

Behaviour:
- All outputs are registered.
- Reset values: `dac_sclk`=0, `dac_cs_n`=1, `dac_mosi`=0, `setup_busy`=0, `setup_done`=0; word index, bit index and divider counters = 0.
- Reset has priority over every other event. Asserting reset mid-frame returns all outputs to reset values on the same edge; no partial-frame completion.
- FSM states: IDLE, FRAME, TAIL, GAP, DONE.
- IDLE:
  - `setup_start`=1 → FRAME with word index 0.
  - On that edge: `dac_cs_n`←0, `setup_busy`←1, `setup_done`←0.
- FRAME:
  - The divider counts CLK_DIV cycles per half-period, then toggles `dac_sclk`.
  - On each 0→1 toggle, `dac_mosi` takes the next bit, MSB first: bit WORD_BITS-1 on the first rising edge.
  - The DAC samples on the following 1→0 edge.
  - After the WORD_BITS-th falling edge → TAIL.
- TAIL: hold `dac_cs_n`=0, `dac_sclk`=0 for CLK_DIV cycles, then `dac_cs_n`←1, `dac_mosi`←0 → GAP.
- GAP:
  - Count GAP_CYCLES.
  - If more words remain: increment word index, `dac_cs_n`←0 → FRAME.
  - Else → DONE, with `setup_busy`←0 and `setup_done`←1.
- DONE:
  - Hold outputs.
  - `setup_start`=1 restarts the sequence from word 0 (as from IDLE; `setup_done`←0).
- `setup_start` while `setup_busy`=1 is ignored.
- Frame timing:
  - `cs_n` low for (2·WORD_BITS+1)·CLK_DIV cycles.
  - Total sequence = NUM_WORDS·((2·WORD_BITS+1)·CLK_DIV + GAP_CYCLES) cycles from the start edge to the `setup_done` edge.
- Word source: constant ROM from the package, indexed 0..NUM_WORDS-1. Default words:
  - 24'h280001: software reset
  - 24'h380001: internal reference on
  - 24'h20000F: power up all channels
  - 24'h1F8000: all channels to mid-scale
- Counter widths are sized with $clog2 of their bounds; no wrap-around occurs within legal parameter ranges.

Optional Feature:
- Macro: SETUP_LASER_INTERLOCK_EN.
- Defined:
  - Adds input `laser_en_req` (1) and output `laser_en` (1).
  - `laser_en` is registered `laser_en_req & setup_done`; resets to 0.
  - Drops to 0 on the edge after a restart clears `setup_done`.
- Undefined: both ports are absent; no interlock logic.

Decomposition:
- Package `laser_dac_pkg`:
  - FSM state enum.
  - DAC command-code constants.
  - Default config ROM array and its word count.
- Sub-module `spi_word_tx`: the serializer implementing the FRAME/TAIL behaviour.
  - Ports: load/word in, busy/word_done out, `sclk`/`mosi`/`cs_n`.
  - `dac_setup_sequencer` owns the word index, the GAP counter and the done/busy flags.

Test Plan:
1. Defaults, `setup_start` pulse at cycle 10 → `cs_n` falls at cycle 11; `setup_done` rises 4·(196+8)=816 cycles after the start edge; `setup_busy` is high throughout.
2. Bit capture on `sclk` falling edges → words 0x280001, 0x380001, 0x20000F, 0x1F8000 in order; exactly 24 falling edges per `cs_n` frame; `cs_n` high for exactly 8 cycles between frames.
3. Second `setup_start` pulse at word 2, bit 5 → ignored; sequence completes at the same cycle as test 1.
4. Reset asserted during word 1 → next edge: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0. A fresh `setup_start` resends from word 0.
5. `setup_start` while DONE → `setup_done` clears next edge; full 4-word sequence repeats; `done` re-asserts after 816 cycles.
6. With SETUP_LASER_INTERLOCK_EN defined and `laser_en_req`=1 from reset:
   - `laser_en`=0 until one cycle after `setup_done`, then 1.
   - A restart drives `laser_en` to 0.
   - CLK_DIV=1 run still yields correct words.

Source files
------------

// File: rtl/laser_dac_pkg.sv
// Shared types and constants for the galvo DAC setup path: FSM states,
// DAC command prefixes and the power-up configuration ROM.
package laser_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_TAIL,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    localparam int unsigned CFG_WORD_BITS = 24;
    typedef logic [CFG_WORD_BITS-1:0] cfg_word_t;

    // Command/address byte in the top 8 bits of each 24-bit DAC word
    localparam logic [7:0] CMD_SW_RESET = 8'h28;
    localparam logic [7:0] CMD_INT_REF  = 8'h38;
    localparam logic [7:0] CMD_POWER_UP = 8'h20;
    localparam logic [7:0] CMD_LOAD_ALL = 8'h1F;

    localparam int unsigned CFG_NUM_WORDS = 4;
    localparam int unsigned CFG_IDX_W     = $clog2(CFG_NUM_WORDS);

    // Element 0 is sent first
    localparam cfg_word_t [CFG_NUM_WORDS-1:0] CFG_ROM = {
        {CMD_LOAD_ALL, 16'h8000},
        {CMD_POWER_UP, 16'h000F},
        {CMD_INT_REF,  16'h0001},
        {CMD_SW_RESET, 16'h0001}
    };

    function automatic cfg_word_t cfg_word(input logic [7:0] idx);
        cfg_word_t w;
        w = '0;
        if (idx < 8'(CFG_NUM_WORDS)) begin
            w = CFG_ROM[idx[CFG_IDX_W-1:0]];
        end
        return w;
    endfunction

endpackage

// File: rtl/dac_setup_sequencer_spi_word_tx.sv
// One chip-select frame of the 3-wire DAC link: MSB-first shift, data
// launched on sclk rise, followed by a one-half-period cs_n tail.
module spi_word_tx
    import laser_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_c,
    input  logic [WORD_BITS-1:0] word,
    output logic                 busy,
    output logic                 word_done_c,
    output logic                 frame_end_c,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    seq_state_e           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WORD_BITS-1:0] sh_q, sh_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 half_end_c;

    assign half_end_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        word_done_c = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_c) begin
                    state_d = ST_FRAME;
                    sh_d    = word;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_FRAME: begin
                if (half_end_c) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        mosi_d = sh_q[WORD_BITS-1];
                    end else begin
                        // DAC has sampled this bit on the falling edge
                        sh_d = sh_q << 1;
                        if (bit_q == BIT_W'(WORD_BITS - 1)) begin
                            state_d     = ST_TAIL;
                            bit_d       = '0;
                            frame_end_c = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_TAIL: begin
                if (half_end_c) begin
                    state_d     = ST_IDLE;
                    div_d       = '0;
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    busy_d      = 1'b0;
                    word_done_c = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

endmodule

// File: rtl/dac_setup_sequencer.sv
// Streams the configuration ROM to the galvo DAC after setup_start, then
// flags setup_done. SETUP_LASER_INTERLOCK_EN adds the laser_en interlock.
module dac_setup_sequencer
    import laser_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned WORD_BITS  = 24,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic setup_start,
`ifdef SETUP_LASER_INTERLOCK_EN
    input  logic laser_en_req,
    output logic laser_en,
`endif
    output logic dac_sclk,
    output logic dac_cs_n,
    output logic dac_mosi,
    output logic setup_busy,
    output logic setup_done
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_ok_c, gap_end_c, last_word_c, load_c;
    logic [IDX_W-1:0]     load_idx_c;
    logic [WORD_BITS-1:0] load_word_c;
    logic                 tx_busy, frame_end_c, word_done_c;

    // A start pulse is honoured only when no sequence is in flight
    assign start_ok_c  = setup_start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign gap_end_c   = (state_q == ST_GAP) && (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) && !tx_busy;
    assign last_word_c = (word_idx_q == IDX_W'(NUM_WORDS - 1));
    assign load_c      = start_ok_c || (gap_end_c && !last_word_c);
    assign load_idx_c  = start_ok_c ? '0 : word_idx_q + IDX_W'(1);
    assign load_word_c = WORD_BITS'(cfg_word(8'(load_idx_c)));

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_c) begin
                    state_d    = ST_FRAME;
                    word_idx_d = '0;
                    gap_cnt_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            ST_FRAME: begin
                if (frame_end_c) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (word_done_c) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_end_c) begin
                    gap_cnt_d = '0;
                    if (last_word_c) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_FRAME;
                        word_idx_d = load_idx_c;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    spi_word_tx #(
        .CLK_DIV   (CLK_DIV),
        .WORD_BITS (WORD_BITS)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .load_c      (load_c),
        .word        (load_word_c),
        .busy        (tx_busy),
        .word_done_c (word_done_c),
        .frame_end_c (frame_end_c),
        .sclk        (dac_sclk),
        .mosi        (dac_mosi),
        .cs_n        (dac_cs_n)
    );

    assign setup_busy = busy_q;
    assign setup_done = done_q;

`ifdef SETUP_LASER_INTERLOCK_EN
    logic laser_en_q, laser_en_d;

    always_comb begin
        laser_en_d = laser_en_req & done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            laser_en_q <= 1'b0;
        end else begin
            laser_en_q <= laser_en_d;
        end
    end

    assign laser_en = laser_en_q;
`endif

endmodule
